sort_frame_loader: RTL and testbench

Sequential front/back end for the combinational max/min sorting network (`maxminN`). Collects M serial N-bit samples into a packed frame, drives it onto the network's `list` input, and captures the network's `res` output one cycle later. It then streams the sorted elements out largest-first with valid/ready handshakes. The block sits between a sample stream source and the downstream consumer; the sorting network hangs off its `list_out`/`sort_res` ports.

---
 rtl/sort_frame_loader.sv | 82 ++++++++
 tb/tb_sort_frame_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_loader.sv
// Collects M samples into a frame for an external combinational sorter, then streams the result max-first.
// Latency: out_valid two cycles after the last accepted sample; fill and drain never overlap; out_ready stalls the drain.
module sort_frame_loader #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_data,
  output logic [M-1:0][N-1:0] list_out,
  input  logic [M-1:0][N-1:0] sort_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data,
  output logic                out_last,
  output logic [7:0]          frames_done
);

  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] SORT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]          state;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic [M-1:0][N-1:0] obuf;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  // Gated so out_data reads zero whenever nothing is being offered.
  assign out_data  = out_valid ? obuf[rd_idx] : '0;
  assign out_last  = out_valid && (rd_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      list_out    <= '0;
      obuf        <= '0;
      frames_done <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            list_out[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= SORT;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          // list_out has been stable for a full cycle, so sort_res has settled.
          obuf   <= sort_res;
          rd_idx <= '0;
          state  <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx      <= '0;
              frames_done <= frames_done + 8'd1;
              state       <= FILL;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed bench for sort_frame_loader with a behavioural descending sorter on list_out/sort_res.
module tb_sort_frame_loader;
  localparam int N = 8;
  localparam int M = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [N-1:0]        in_data = '0;
  logic [M-1:0][N-1:0] list_out;
  logic [M-1:0][N-1:0] sort_res;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [N-1:0]        out_data;
  logic                out_last;
  logic [7:0]          frames_done;

  int n_vec = 0;
  int n_err = 0;

  sort_frame_loader #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .list_out(list_out), .sort_res(sort_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sort_desc(input logic [31:0] l);
    logic [7:0] a [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) a[i] = l[8*i +: 8];
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 3; j++)
        if (a[j] < a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  assign sort_res = sort_desc(list_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one sample at a negedge and return at the negedge after it is accepted.
  task automatic send(input logic [7:0] v);
    logic hs;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 40; k++) begin
      hs = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs) return;
    end
    check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic l);
    int k;
    out_ready = 1'b1;
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'(1));
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_last"}, 32'(out_last), 32'(l));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_free();
    logic done;
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      done = out_valid && out_last;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) check("drain_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_list", 32'(list_out), 32'(0));
    check("rst_frames", 32'(frames_done), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic sort with exact latency
    send_frame(8'd3, 8'd9, 8'd1, 8'd7);
    check("basic_list", 32'(list_out), 32'h07010903);
    check("basic_sort_in_ready", 32'(in_ready), 32'(0));
    check("basic_sort_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("basic_lat_valid", 32'(out_valid), 32'(1));
    expect_out("basic0", 8'd9, 1'b0);
    expect_out("basic1", 8'd7, 1'b0);
    expect_out("basic2", 8'd3, 1'b0);
    check("basic_drain_in_ready", 32'(in_ready), 32'(0));
    expect_out("basic3", 8'd1, 1'b1);
    check("basic_back_in_ready", 32'(in_ready), 32'(1));
    check("basic_back_valid", 32'(out_valid), 32'(0));
    check("basic_frames", 32'(frames_done), 32'(1));

    // Duplicates and extremes
    send_frame(8'd0, 8'd255, 8'd255, 8'd0);
    expect_out("dup0", 8'd255, 1'b0);
    expect_out("dup1", 8'd255, 1'b0);
    expect_out("dup2", 8'd0, 1'b0);
    expect_out("dup3", 8'd0, 1'b1);
    check("dup_frames", 32'(frames_done), 32'(2));

    // Backpressure at rd_idx=1 with in_valid held high
    send_frame(8'd5, 8'd9, 8'd2, 8'd7);
    expect_out("bp0", 8'd9, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd99;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(out_data), 32'(7));
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_hold_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
    end
    check("bp_list_stable", 32'(list_out), 32'h07020905);
    in_valid = 1'b0;
    expect_out("bp1", 8'd7, 1'b0);
    expect_out("bp2", 8'd5, 1'b0);
    expect_out("bp3", 8'd2, 1'b1);
    check("bp_frames", 32'(frames_done), 32'(3));
    check("bp_list_after", 32'(list_out), 32'h07020905);

    // Gapped input with junk on idle cycles
    out_ready = 1'b0;
    in_valid = 1'b0; in_data = 8'd77; @(negedge clk); @(negedge clk);
    send(8'd10);
    in_valid = 1'b0; in_data = 8'd66; @(negedge clk);
    send(8'd20);
    send(8'd30);
    in_valid = 1'b0; in_data = 8'd55; @(negedge clk); @(negedge clk); @(negedge clk);
    check("gap_partial_list", 32'(list_out), 32'h071e140a);
    check("gap_partial_in_ready", 32'(in_ready), 32'(1));
    check("gap_partial_valid", 32'(out_valid), 32'(0));
    send(8'd40);
    in_valid = 1'b0;
    check("gap_full_list", 32'(list_out), 32'h281e140a);
    expect_out("gap0", 8'd40, 1'b0);
    expect_out("gap1", 8'd30, 1'b0);
    expect_out("gap2", 8'd20, 1'b0);
    expect_out("gap3", 8'd10, 1'b1);
    check("gap_frames", 32'(frames_done), 32'(4));

    // Reset in the middle of a drain
    send_frame(8'd1, 8'd2, 8'd3, 8'd4);
    expect_out("mr0", 8'd4, 1'b0);
    expect_out("mr1", 8'd3, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'(0));
    check("mr_in_ready", 32'(in_ready), 32'(1));
    check("mr_frames", 32'(frames_done), 32'(0));
    check("mr_out_data", 32'(out_data), 32'(0));
    check("mr_list", 32'(list_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'd4, 8'd2, 8'd8, 8'd6);
    expect_out("ar0", 8'd8, 1'b0);
    expect_out("ar1", 8'd6, 1'b0);
    expect_out("ar2", 8'd4, 1'b0);
    expect_out("ar3", 8'd2, 1'b1);
    check("ar_frames", 32'(frames_done), 32'(1));

    // Counter wrap: 254 more frames reach 255, one more wraps to 0
    for (int f = 0; f < 254; f++) begin
      send_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      drain_free();
    end
    check("wrap_255", 32'(frames_done), 32'(255));
    send_frame(8'd11, 8'd12, 8'd13, 8'd14);
    expect_out("wr0", 8'd14, 1'b0);
    expect_out("wr1", 8'd13, 1'b0);
    expect_out("wr2", 8'd12, 1'b0);
    expect_out("wr3", 8'd11, 1'b1);
    check("wrap_0", 32'(frames_done), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
